rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Staged reset-release sequencer that sits directly downstream of the async-assert/sync-release reset bridge.
- The bridge's synchronised reset output drives this block's async_rst_n.
- Waits for clock lock, then releases NUM_STAGES subsystem resets one at a time in a fixed order, with programmable gaps between releases.
- Supports a software-requested warm reset and forces immediate re-assertion on loss of lock.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (>=1); stage 0 is released first.
- INIT_WAIT, 16, cycles spent in INIT before stage 0 is released (>=1).
- STAGE_GAP, 8, cycles between consecutive stage releases, and from the last release to rst_done (>=1).
- SW_HOLD, 32, cycles all stages are held in reset after a software request (>=1).
- CNT_W, 8, counter width; must hold max(INIT_WAIT, STAGE_GAP, SW_HOLD)-1.

Ports:
- clk  input  1  sequencer clock.
- async_rst_n  input  1  asynchronous, active-low reset; driven by the reset bridge output, so it is already release-synchronised to clk.
- lock_i  input  1  PLL/clock lock indicator; asynchronous to clk.
- sw_rst_req  input  1  single-cycle software warm-reset request, clk domain.
- stage_rst_n  output  NUM_STAGES  per-stage active-low resets, registered.
- rst_done  output  1  high when all stages are released and the final gap has elapsed.
- seq_state  output  3  current FSM state encoding, for debug/status.

Behaviour:
- Reset (async_rst_n=0, asynchronous):
  - state=WAIT_LOCK (0), cnt=0, idx=0.
  - lock synchroniser flops=0.
  - stage_rst_n=all 0, rst_done=0.
- Lock synchroniser: lock_i passes through a 2-flop synchroniser to give lock_s; latency 2 edges. All decisions use lock_s only.
- State encoding: WAIT_LOCK=0, INIT=1, RELEASE=2, DONE=3, SW_HOLD=4. Values 5-7 are illegal and recover to WAIT_LOCK with all stages held in reset.
- WAIT_LOCK:
  - stage_rst_n=0, rst_done=0.
  - When lock_s=1 -> INIT, cnt=0.
- INIT:
  - cnt increments each cycle.
  - At cnt==INIT_WAIT-1 -> RELEASE, cnt=0, idx=0, and stage_rst_n[0]<=1 on the same edge.
  - Result: stage 0 rises exactly INIT_WAIT cycles after INIT is entered.
- RELEASE:
  - cnt increments each cycle.
  - At cnt==STAGE_GAP-1 with idx<NUM_STAGES-1: idx<=idx+1, stage_rst_n[idx+1]<=1, cnt=0.
  - At cnt==STAGE_GAP-1 with idx==NUM_STAGES-1: -> DONE, rst_done<=1.
  - Released stages stay high; stage bits only rise in index order, never out of order.
- DONE:
  - stage_rst_n=all 1, rst_done=1.
  - sw_rst_req=1 -> next edge: stage_rst_n=all 0, rst_done=0, cnt=0, state SW_HOLD.
- SW_HOLD:
  - Counts SW_HOLD cycles.
  - At cnt==SW_HOLD-1 -> INIT (full sequence re-runs) if lock_s=1, else -> WAIT_LOCK.
- Lock loss: lock_s=0 in INIT, RELEASE, DONE or SW_HOLD -> next edge: stage_rst_n=all 0, rst_done=0, cnt=0, idx=0, state WAIT_LOCK.
- Priority: async_rst_n > lock loss > sw_rst_req > counter progress. A lock loss coincident with sw_rst_req goes to WAIT_LOCK.
- sw_rst_req outside DONE is ignored and is not queued.
- NUM_STAGES=1: stage 0 releases after INIT; rst_done follows STAGE_GAP cycles later.
- Reset asserted mid-sequence: all outputs drop asynchronously; the sequence restarts from WAIT_LOCK once async_rst_n releases.
- rst_done=1 implies stage_rst_n=all 1 in every cycle.

Test Plan:
- Power-up, defaults, lock_i tied 1, release async_rst_n -> INIT entered after 2-edge sync; stage_rst_n goes 0000->0001 at INIT+16, 0011 at +24, 0111 at +32, 1111 at +40; rst_done=1 at +48.
- lock_i held 0 for 100 cycles after reset -> stage_rst_n stays 0000, seq_state=0 throughout; raising lock_i starts the sequence as above.
- In DONE, pulse sw_rst_req for 1 cycle -> next edge stage_rst_n=0000, rst_done=0, seq_state=4 for 32 cycles; then the full INIT/RELEASE sequence repeats to rst_done=1.
- Drop lock_i while stage_rst_n=0011 -> 2 edges later plus 1, stage_rst_n=0000, seq_state=0; a sw_rst_req in the same cycle has no extra effect.
- Pulse async_rst_n low mid-RELEASE -> outputs 0 immediately (asynchronously); after release the sequence restarts cleanly with correct timing.
- Pulse sw_rst_req during INIT and RELEASE -> ignored; release timing is unchanged from the first scenario.

Source files
------------

// File: rtl/rst_sequencer_if.sv
// Status and control bundle of the staged reset sequencer.
// The slave side is the sequencer itself; the master side is whoever
// supplies the lock indicator and software requests and observes the
// staged resets.
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  lock_i;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  rst_done;
    logic [2:0]            seq_state;

    modport master (
        output lock_i,
        output sw_rst_req,
        input  stage_rst_n,
        input  rst_done,
        input  seq_state
    );

    modport slave (
        input  lock_i,
        input  sw_rst_req,
        output stage_rst_n,
        output rst_done,
        output seq_state
    );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer.
// Sits behind the reset bridge: waits for a synchronised clock-lock
// indication, then releases NUM_STAGES active-low subsystem resets one
// at a time (stage 0 first) with fixed gaps. Supports a software warm
// reset from DONE and drops every stage on loss of lock.
module rst_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int INIT_WAIT  = 16,
    parameter int STAGE_GAP  = 8,
    parameter int SW_HOLD    = 32,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             async_rst_n,
    rst_sequencer_if.slave   bus
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    // Encodings are visible on seq_state, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_INIT      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_DONE      = 3'd3,
        ST_SW_HOLD   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q,  done_d;

    logic                  lock_meta;
    logic                  lock_s;

    // Two-flop synchroniser for the asynchronous lock indicator.
    // NOTE: every flop, synchroniser included, is cleared by async_rst_n so a
    // stale lock_s can never skip WAIT_LOCK after a reset pulse.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so lock_s sees the old lock_meta.
            lock_meta <= bus.lock_i;
            lock_s    <= lock_meta;
        end
    end

    // State, counter, stage index and registered outputs.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: lock loss beats software request beats counting.
    always_comb begin
        // NOTE: hold-current defaults first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;

        if (state_q != ST_WAIT_LOCK && !lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                    if (lock_s) begin
                        state_d = ST_INIT;
                    end
                end

                ST_INIT: begin
                    if (cnt_q == INIT_LAST) begin
                        state_d    = ST_RELEASE;
                        cnt_d      = '0;
                        idx_d      = '0;
                        stage_d[0] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            stage_d = '1;
                            done_d  = 1'b1;
                        end else begin
                            idx_d                        = idx_q + IDX_W'(1);
                            stage_d[idx_q + IDX_W'(1)]   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    stage_d = '1;
                    done_d  = 1'b1;
                    if (bus.sw_rst_req) begin
                        state_d = ST_SW_HOLD;
                        cnt_d   = '0;
                        stage_d = '0;
                        done_d  = 1'b0;
                    end
                end

                ST_SW_HOLD: begin
                    stage_d = '0;
                    done_d  = 1'b0;
                    // Lock is known good here; loss was handled above.
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    // Encodings 5-7 recover with every stage held in reset.
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.stage_rst_n = stage_q;
    assign bus.rst_done    = done_q;
    assign bus.seq_state   = state_q;

endmodule
